// File: rtl/ofdm_preamble_pkg.sv
// ofdm_preamble_pkg
//   Shared constants for the OFDM preamble inserter and detector: the 256-bit
//   BPSK sign patterns for I and Q (bit = 1 -> +A, 0 -> -A, read MSB first)
//   and the inserter FSM state encoding.
package ofdm_preamble_pkg;

    localparam logic [255:0] PRE_I =
        256'hA5C3_96F0_1E2D_7B48_C93A_0F5E_6D21_B874_3E9C_52A7_F016_8DB4_27C5_E93A_4F61_0DB8;
    localparam logic [255:0] PRE_Q =
        256'h5B1E_C472_8F3D_09A6_E25C_71B4_3D8F_A609_C17E_5B23_94D0_6FA8_0E3B_D752_A96C_14F7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_GUARD    = 2'd2,
        ST_PAYLOAD  = 2'd3
    } state_e;

endpackage

// File: rtl/ofdm_preamble_seq.sv
// ofdm_preamble_seq
//   Index counter plus constant pattern lookup. The counter walks 0..limit_i-1
//   on each step_i and wraps to 0 on the final step. The I/Q outputs are the
//   +/-A pair for the current index (pattern read MSB first); done_o flags the
//   step that consumes index limit_i-1.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   step_i          advance the index
//   limit_i         number of indices in the current phase
//   smp_i_o/smp_q_o +/-A sample for the current index
//   done_o          step_i on the last index of the phase
module ofdm_preamble_seq
    import ofdm_preamble_pkg::*;
#(
    parameter int                      DATA_SIZE    = 16,
    parameter int                      PREAMBLE_LEN = 256,
    parameter logic [PREAMBLE_LEN-1:0] MEM_I        = PRE_I,
    parameter logic [PREAMBLE_LEN-1:0] MEM_Q        = PRE_Q,
    parameter int                      AMPLITUDE    = 8192,
    parameter int                      CW           = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_i,
    input  logic [CW-1:0]        limit_i,
    output logic [DATA_SIZE-1:0] smp_i_o,
    output logic [DATA_SIZE-1:0] smp_q_o,
    output logic                 done_o
);

    localparam int IW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam logic [DATA_SIZE-1:0] POS_A = DATA_SIZE'(AMPLITUDE);
    localparam logic [DATA_SIZE-1:0] NEG_A = DATA_SIZE'(-AMPLITUDE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] idx;
    logic          last;

    assign last   = (cnt_q == limit_i - CW'(1));
    assign done_o = step_i & last;

    // Sample k of the preamble lives at bit PREAMBLE_LEN-1-k. During the guard
    // phase the index runs over the same counter but the lookup is ignored.
    assign idx     = IW'(PREAMBLE_LEN - 1 - int'(cnt_q));
    assign smp_i_o = MEM_I[idx] ? POS_A : NEG_A;
    assign smp_q_o = MEM_Q[idx] ? POS_A : NEG_A;

    always_comb begin
        cnt_d = cnt_q;
        if (step_i) cnt_d = last ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ofdm_preamble_inserter.sv
// ofdm_preamble_inserter
//   On start, emits the PREAMBLE_LEN-sample BPSK preamble, GUARD_LEN zero
//   samples, then forwards one payload frame (through in_last) from the
//   modulator. Single registered output stage with valid/ready handshake.
// Ports
//   clk, rst                clock, synchronous active-high reset
//   start                   frame request, honoured only in IDLE
//   in_data_i/q, in_valid,
//   in_last, in_ready       payload stream in (in_ready is combinational)
//   out_data_i/q, out_valid,
//   out_ready, out_first    sample stream out; out_first marks preamble sample 0
//   busy                    high outside IDLE
//   underrun                pulse when the payload source failed to supply a sample
module ofdm_preamble_inserter
    import ofdm_preamble_pkg::*;
#(
    parameter int                      DATA_SIZE      = 16,
    parameter int                      PREAMBLE_LEN   = 256,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_MEM_I = PRE_I,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_MEM_Q = PRE_Q,
    parameter int                      AMPLITUDE      = 8192,
    parameter int                      GUARD_LEN      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] out_data_i,
    output logic [DATA_SIZE-1:0] out_data_q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 busy,
    output logic                 underrun
);

    localparam int MAXLEN = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
    localparam int CW     = $clog2(MAXLEN + 1);

    state_e               state_q;
    logic [DATA_SIZE-1:0] out_i_q;
    logic [DATA_SIZE-1:0] out_q_q;
    logic                 out_valid_q;
    logic                 out_first_q;
    logic                 underrun_q;

    logic                 adv;
    logic                 seq_step;
    logic [CW-1:0]        seq_limit;
    logic [DATA_SIZE-1:0] seq_i;
    logic [DATA_SIZE-1:0] seq_q;
    logic                 seq_done;

    // Output register is free to load when empty or being drained this cycle.
    assign adv = ~out_valid_q | out_ready;

    assign seq_limit = (state_q == ST_GUARD) ? CW'(GUARD_LEN) : CW'(PREAMBLE_LEN);
    assign seq_step  = adv & (((state_q == ST_IDLE) & start) |
                              (state_q == ST_PREAMBLE) |
                              (state_q == ST_GUARD));

    ofdm_preamble_seq #(
        .DATA_SIZE   (DATA_SIZE),
        .PREAMBLE_LEN(PREAMBLE_LEN),
        .MEM_I       (PREAMBLE_MEM_I),
        .MEM_Q       (PREAMBLE_MEM_Q),
        .AMPLITUDE   (AMPLITUDE),
        .CW          (CW)
    ) u_seq (
        .clk    (clk),
        .rst    (rst),
        .step_i (seq_step),
        .limit_i(seq_limit),
        .smp_i_o(seq_i),
        .smp_q_o(seq_q),
        .done_o (seq_done)
    );

    // Payload goes straight into the output register, so the source is
    // only ready when that register can take a sample.
    assign in_ready   = (state_q == ST_PAYLOAD) & adv;
    assign out_data_i = out_i_q;
    assign out_data_q = out_q_q;
    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (adv) begin
                case (state_q)
                    ST_IDLE: begin
                        // A start that arrives while the last payload sample is
                        // still stalled waits out nothing: it is simply dropped,
                        // like any other start outside an accepting IDLE cycle.
                        if (start) begin
                            out_i_q     <= seq_i;
                            out_q_q     <= seq_q;
                            out_valid_q <= 1'b1;
                            out_first_q <= 1'b1;
                            state_q     <= ST_PREAMBLE;
                        end else begin
                            out_valid_q <= 1'b0;
                            out_first_q <= 1'b0;
                        end
                    end
                    ST_PREAMBLE: begin
                        out_i_q     <= seq_i;
                        out_q_q     <= seq_q;
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b0;
                        if (seq_done)
                            state_q <= (GUARD_LEN == 0) ? ST_PAYLOAD : ST_GUARD;
                    end
                    ST_GUARD: begin
                        out_i_q     <= '0;
                        out_q_q     <= '0;
                        out_valid_q <= 1'b1;
                        out_first_q <= 1'b0;
                        if (seq_done) state_q <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        // A missing input sample becomes an output bubble.
                        out_i_q     <= in_data_i;
                        out_q_q     <= in_data_q;
                        out_valid_q <= in_valid;
                        out_first_q <= 1'b0;
                        underrun_q  <= ~in_valid;
                        if (in_valid & in_last) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofdm_preamble_inserter.sv
module tb_ofdm_preamble_inserter;
    import ofdm_preamble_pkg::*;

    localparam int NPRE = 256;
    localparam int NGRD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_data_i = '0;
    logic [15:0] in_data_q = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] out_data_i;
    logic [15:0] out_data_q;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_first;
    logic        busy;
    logic        underrun;

    always #5 clk = ~clk;

    ofdm_preamble_inserter #(
        .DATA_SIZE     (16),
        .PREAMBLE_LEN  (NPRE),
        .PREAMBLE_MEM_I(PRE_I),
        .PREAMBLE_MEM_Q(PRE_Q),
        .AMPLITUDE     (8192),
        .GUARD_LEN     (NGRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data_i (in_data_i),
        .in_data_q (in_data_q),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data_i(out_data_i),
        .out_data_q(out_data_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .busy      (busy),
        .underrun  (underrun)
    );

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        first;
    } smp_t;

    smp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   acc_cnt  = 0;
    int   urun_cnt = 0;
    bit   bp_mode  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] pay_i(input int k);
        return 16'(k * 4369 + 32'h8123);
    endfunction
    function automatic logic [15:0] pay_q(input int k);
        return 16'(32'h7FFF - k * 1021);
    endfunction

    // Expected frame: +8192 = 16'h2000, -8192 = 16'hE000, MSB of the pattern first.
    task automatic push_frame(input int n);
        logic [255:0] pi;
        logic [255:0] pq;
        smp_t s;
        pi = PRE_I;
        pq = PRE_Q;
        for (int k = 0; k < NPRE; k++) begin
            s.i = pi[255-k] ? 16'h2000 : 16'hE000;
            s.q = pq[255-k] ? 16'h2000 : 16'hE000;
            s.first = (k == 0);
            exp_q.push_back(s);
        end
        for (int k = 0; k < NGRD; k++) begin
            s.i = 16'h0000; s.q = 16'h0000; s.first = 1'b0;
            exp_q.push_back(s);
        end
        for (int k = 0; k < n; k++) begin
            s.i = pay_i(k); s.q = pay_q(k); s.first = 1'b0;
            exp_q.push_back(s);
        end
    endtask

    // Downstream ready: steady high, or toggling every cycle under backpressure.
    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = ~out_ready;
        else         out_ready = 1'b1;
    end

    // Monitor: scoreboard pop on every handshake, plus hold check while stalled.
    smp_t held;
    bit   stalled = 1'b0;
    always @(negedge clk) begin
        smp_t s;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (underrun) urun_cnt++;
            if (stalled)
                check("stall_hold", {out_valid, out_data_i, out_data_q, out_first}, {1'b1, held});
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                held = {out_data_i, out_data_q, out_first};
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0h/%0h, expected none", out_data_i, out_data_q);
                end else begin
                    s = exp_q.pop_front();
                    check("sample", {out_data_i, out_data_q, out_first}, s);
                end
                acc_cnt++;
            end
        end
    end

    // Payload source: presents sample i until accepted; optional gap of
    // gap_len idle cycles after gap_at samples; optional start pulses.
    task automatic drive_payload(input int n, input int gap_at, input int gap_len,
                                 input int busy_at, input bit start_on_last);
        int  i   = 0;
        int  gap = 0;
        int  cyc = 0;
        bit  acc;
        while (i < n && cyc < 5000) begin
            if (gap > 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                gap--;
            end else begin
                in_valid  = 1'b1;
                in_data_i = pay_i(i);
                in_data_q = pay_q(i);
                in_last   = (i == n - 1);
                if (start_on_last && i == n - 1) start = 1'b1;
            end
            if (cyc == busy_at) start = 1'b1;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (acc) begin
                i++;
                if (i == gap_at) gap = gap_len;
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("payload_sent", i, n);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !out_valid && !busy) done = 1'b1;
        end
        check("drain_done", done, 1'b1);
    endtask

    task automatic run_frame(input int n, input int gap_at, input int gap_len, input bit bp,
                             input int busy_at, input bit start_on_last, input int exp_urun);
        acc_cnt  = 0;
        urun_cnt = 0;
        bp_mode  = bp;
        push_frame(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("latency_valid", out_valid, 1'b1);
        check("latency_first", out_first, 1'b1);
        drive_payload(n, gap_at, gap_len, busy_at, start_on_last);
        wait_drain();
        bp_mode = 1'b0;
        check("sample_count", acc_cnt, NPRE + NGRD + n);
        check("underrun_count", urun_cnt, exp_urun);
        check("idle_busy", busy, 1'b0);
        check("idle_in_ready", in_ready, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_first", out_first, 1'b0);
        check("rst_data", {out_data_i, out_data_q}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: full frame, out_ready held high
        run_frame(8, -1, 0, 1'b0, -1, 1'b0, 0);

        // 3: backpressure toggling every cycle
        run_frame(6, -1, 0, 1'b1, -1, 1'b0, 0);

        // 4: three-cycle payload bubble after the 4th sample
        run_frame(8, 4, 3, 1'b0, -1, 1'b0, 3);

        // 5: start during preamble and on the in_last cycle are both ignored
        run_frame(5, -1, 0, 1'b0, 50, 1'b1, 0);
        repeat (20) @(posedge clk);
        #2;
        check("no_second_frame_busy", busy, 1'b0);
        check("no_second_frame_cnt", acc_cnt, NPRE + NGRD + 5);

        // 6: reset mid-preamble, then restart from sample 0
        acc_cnt = 0;
        push_frame(0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 1000 && !hit; c++) begin
                @(posedge clk);
                #2;
                if (acc_cnt >= 100) hit = 1'b1;
            end
            check("reach_sample_100", hit, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        run_frame(4, -1, 0, 1'b0, -1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
